// File: rtl/m107_sdr_arbiter.sv
// m107_sdr_arbiter
// Sequencer for the shared CPU-side SDRAM channel. Arbitrates a CPU requester
// and a sprite/palette DMA requester onto one toggle-handshake SDRAM port.
// Completion is signalled with a one-cycle ready/ack pulse. CPU writes to
// non-writable regions are absorbed without touching SDRAM.
//
// Optional feature: define M107_SDR_READ_CACHE_EN to add a single-entry CPU
// read cache (valid + 25-bit tag + 16-bit data).
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   cpu_req/addr/writable/we/be/din    CPU access request (level)
//   cpu_dout, cpu_ready                CPU read data and completion pulse
//   dma_req/addr/we/din                DMA access request (level)
//   dma_dout, dma_ack                  DMA read data and completion pulse
//   sdr_addr/din/be/we/req             registered SDRAM command, req is a toggle
//   sdr_ack, sdr_dout                  SDRAM acknowledge toggle and read data
module m107_sdr_arbiter #(
  parameter int STREAK_MAX = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [24:0] cpu_addr,
  input  logic        cpu_writable,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_be,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic [24:0] dma_addr,
  input  logic        dma_we,
  input  logic [15:0] dma_din,
  output logic [15:0] dma_dout,
  output logic        dma_ack,
  output logic [24:0] sdr_addr,
  output logic [15:0] sdr_din,
  output logic [1:0]  sdr_be,
  output logic        sdr_we,
  output logic        sdr_req,
  input  logic        sdr_ack,
  input  logic [15:0] sdr_dout
);

  localparam logic [1:0] STREAK_LIM = 2'(STREAK_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r, state_nxt;
  logic        owner_r, owner_nxt;     // 1'b1 = DMA owns the current access
  logic [1:0]  streak_r, streak_nxt;
  logic        drop_s, hit_s, match_s;

  logic [24:0] sdr_addr_r;
  logic [15:0] sdr_din_r;
  logic [1:0]  sdr_be_r;
  logic        sdr_we_r;
  logic        sdr_req_r;
  logic [15:0] cpu_dout_r, dma_dout_r;
  logic        cpu_ready_r, dma_ack_r;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'b11) ? 2'b11 : v + 2'd1;
  endfunction

  assign drop_s  = cpu_req & cpu_we & ~cpu_writable;
  assign match_s = (sdr_ack == sdr_req_r);

`ifdef M107_SDR_READ_CACHE_EN
  logic        cache_valid_r;
  logic [24:0] cache_tag_r;
  logic [15:0] cache_data_r;

  assign hit_s = cpu_req & ~cpu_we & cache_valid_r & (cache_tag_r == cpu_addr);

  // Single-entry read cache: fill on CPU read completion, drop on any write completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_valid_r <= 1'b0;
      cache_tag_r   <= 25'd0;
      cache_data_r  <= 16'd0;
    end else if (state_r == WAIT && match_s) begin
      if (sdr_we_r) begin
        cache_valid_r <= 1'b0;
      end else if (!owner_r) begin
        cache_valid_r <= 1'b1;
        cache_tag_r   <= sdr_addr_r;
        cache_data_r  <= sdr_dout;
      end
    end
  end
`else
  assign hit_s = 1'b0;
`endif

  // State, owner and starvation counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      owner_r  <= 1'b0;
      streak_r <= 2'd0;
    end else begin
      state_r  <= state_nxt;
      owner_r  <= owner_nxt;
      streak_r <= streak_nxt;
    end
  end

  // Next-state, arbitration and streak update.
  always_comb begin
    state_nxt  = state_r;
    owner_nxt  = owner_r;
    streak_nxt = streak_r;
    case (state_r)
      IDLE: begin
        if (drop_s || hit_s) begin
          // Served without SDRAM; not a grant, so streak only follows dma_req.
          state_nxt = DONE;
          owner_nxt = 1'b0;
          if (!dma_req) begin
            streak_nxt = 2'd0;
          end else begin
            streak_nxt = streak_r;
          end
        end else if (cpu_req || dma_req) begin
          state_nxt = ISSUE;
          if (dma_req && (!cpu_req || streak_r == STREAK_LIM)) begin
            owner_nxt  = 1'b1;
            streak_nxt = 2'd0;
          end else begin
            owner_nxt = 1'b0;
            if (dma_req) begin
              streak_nxt = sat_inc(streak_r);
            end else begin
              streak_nxt = 2'd0;
            end
          end
        end else begin
          streak_nxt = 2'd0;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (match_s) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // SDRAM command, read data capture and completion pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdr_addr_r  <= 25'd0;
      sdr_din_r   <= 16'd0;
      sdr_be_r    <= 2'b00;
      sdr_we_r    <= 1'b0;
      sdr_req_r   <= 1'b0;
      cpu_dout_r  <= 16'd0;
      dma_dout_r  <= 16'd0;
      cpu_ready_r <= 1'b0;
      dma_ack_r   <= 1'b0;
    end else begin
      cpu_ready_r <= 1'b0;
      dma_ack_r   <= 1'b0;
      if (state_r == ISSUE) begin
        sdr_addr_r <= owner_r ? dma_addr : cpu_addr;
        sdr_din_r  <= owner_r ? dma_din : cpu_din;
        sdr_be_r   <= owner_r ? 2'b11 : cpu_be;
        sdr_we_r   <= owner_r ? dma_we : cpu_we;
        sdr_req_r  <= ~sdr_req_r;
      end
      if (state_r == WAIT && match_s) begin
        if (owner_r) begin
          dma_dout_r <= sdr_dout;
          dma_ack_r  <= 1'b1;
        end else begin
          cpu_dout_r  <= sdr_dout;
          cpu_ready_r <= 1'b1;
        end
      end
      if (state_r == IDLE && (drop_s || hit_s)) begin
        cpu_ready_r <= 1'b1;
`ifdef M107_SDR_READ_CACHE_EN
        if (hit_s) begin
          cpu_dout_r <= cache_data_r;
        end
`endif
      end
    end
  end

  assign sdr_addr  = sdr_addr_r;
  assign sdr_din   = sdr_din_r;
  assign sdr_be    = sdr_be_r;
  assign sdr_we    = sdr_we_r;
  assign sdr_req   = sdr_req_r;
  assign cpu_dout  = cpu_dout_r;
  assign dma_dout  = dma_dout_r;
  assign cpu_ready = cpu_ready_r;
  assign dma_ack   = dma_ack_r;

endmodule
